// File: rtl/iter_alu.sv
// Iterative ALU: single-cycle integer ops plus XLEN-cycle shift-add multiply
// and restoring divide, behind a valid/ready request/result handshake.
module iter_alu #(
  parameter int XLEN = 32,
  parameter int SHW  = $clog2(XLEN)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [4:0]      op,
  input  logic [XLEN-1:0] operand1,
  input  logic [XLEN-1:0] operand2,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  input  logic            flush
);
  localparam int CW = $clog2(XLEN);

  localparam logic [4:0] OP_ADD    = 5'd0,  OP_SUB  = 5'd1,  OP_XOR  = 5'd2,  OP_OR   = 5'd3;
  localparam logic [4:0] OP_AND    = 5'd4,  OP_SLL  = 5'd5,  OP_SRL  = 5'd6,  OP_SRA  = 5'd7;
  localparam logic [4:0] OP_SLT    = 5'd8,  OP_SLTU = 5'd9,  OP_PASS2 = 5'd10, OP_CLR = 5'd11;
  localparam logic [4:0] OP_PASS1  = 5'd12;
  localparam logic [4:0] OP_MUL    = 5'd16, OP_MULH = 5'd17, OP_MULHSU = 5'd18, OP_MULHU = 5'd19;
  localparam logic [4:0] OP_DIV    = 5'd20, OP_DIVU = 5'd21, OP_REM  = 5'd22, OP_REMU = 5'd23;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  typedef struct packed {
    logic [4:0]      op;
    logic [XLEN-1:0] a;
    logic [XLEN-1:0] b;
  } req_t;

  state_t          state, state_nxt;
  req_t            req_q;
  logic [CW-1:0]   cnt;
  logic [XLEN-1:0] hi, lo, mc;
  logic [XLEN-1:0] hi_nxt, lo_nxt;
  logic [XLEN-1:0] alu_res, it_res, res_nxt;
  logic            accept, multi, ld_res;

  function automatic logic sgn1(input logic [4:0] o);
    return (o == OP_MULH) || (o == OP_MULHSU) || (o == OP_DIV) || (o == OP_REM);
  endfunction

  function automatic logic sgn2(input logic [4:0] o);
    return (o == OP_MULH) || (o == OP_DIV) || (o == OP_REM);
  endfunction

  assign in_ready  = (state == IDLE) || ((state == DONE) && out_ready);
  assign out_valid = (state == DONE);
  assign accept    = in_valid && in_ready && !flush;
  assign multi     = (op[4:3] == 2'b10);

  // Single-step results, computed straight from the request inputs.
  logic [SHW-1:0] shamt;
  assign shamt = operand2[SHW-1:0];

  always_comb begin
    alu_res = '0;
    case (op)
      OP_ADD:   alu_res = operand1 + operand2;
      OP_SUB:   alu_res = operand1 - operand2;
      OP_XOR:   alu_res = operand1 ^ operand2;
      OP_OR:    alu_res = operand1 | operand2;
      OP_AND:   alu_res = operand1 & operand2;
      OP_SLL:   alu_res = operand1 << shamt;
      OP_SRL:   alu_res = operand1 >> shamt;
      OP_SRA:   alu_res = $signed(operand1) >>> shamt;
      OP_SLT:   alu_res = {{(XLEN-1){1'b0}}, $signed(operand1) < $signed(operand2)};
      OP_SLTU:  alu_res = {{(XLEN-1){1'b0}}, operand1 < operand2};
      OP_PASS2: alu_res = operand2;
      OP_CLR:   alu_res = ~operand1 & operand2;
      OP_PASS1: alu_res = operand1;
      default:  alu_res = '0;
    endcase
  end

  // Both engines iterate on operand magnitudes; signs are re-applied at the end.
  logic            in_n1, in_n2;
  logic [XLEN-1:0] ma, mb;
  assign in_n1 = sgn1(op) && operand1[XLEN-1];
  assign in_n2 = sgn2(op) && operand2[XLEN-1];
  assign ma    = in_n1 ? -operand1 : operand1;
  assign mb    = in_n2 ? -operand2 : operand2;

  logic [XLEN:0]   sum, sh;
  logic [XLEN-1:0] diff;
  logic            ge;

  always_comb begin
    sum  = {1'b0, hi} + (lo[0] ? {1'b0, mc} : '0);
    sh   = {hi, lo[XLEN-1]};
    ge   = (sh >= {1'b0, mc});
    diff = sh[XLEN-1:0] - mc;
    if (req_q.op[2]) begin
      hi_nxt = ge ? diff : sh[XLEN-1:0];
      lo_nxt = {lo[XLEN-2:0], ge};
    end else begin
      hi_nxt = sum[XLEN:1];
      lo_nxt = {sum[0], lo[XLEN-1:1]};
    end
  end

  // Final result from the last iteration's values, so DONE lands on the XLEN-th BUSY edge.
  logic              q_n1, q_n2, dz, ovf;
  logic [2*XLEN-1:0] prod, prod_s;

  always_comb begin
    q_n1   = sgn1(req_q.op) && req_q.a[XLEN-1];
    q_n2   = sgn2(req_q.op) && req_q.b[XLEN-1];
    dz     = (req_q.b == '0);
    ovf    = sgn2(req_q.op) && (req_q.a == {1'b1, {(XLEN-1){1'b0}}}) && (req_q.b == '1);
    prod   = {hi_nxt, lo_nxt};
    prod_s = (q_n1 ^ q_n2) ? -prod : prod;
    it_res = '0;
    case (req_q.op)
      OP_MUL:                        it_res = prod_s[XLEN-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU:  it_res = prod_s[2*XLEN-1:XLEN];
      OP_DIV, OP_DIVU:
        if (dz)       it_res = '1;
        else if (ovf) it_res = req_q.a;
        else          it_res = (q_n1 ^ q_n2) ? -lo_nxt : lo_nxt;
      OP_REM, OP_REMU:
        if (dz)       it_res = req_q.a;
        else if (ovf) it_res = '0;
        else          it_res = q_n1 ? -hi_nxt : hi_nxt;
      default:        it_res = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    ld_res    = 1'b0;
    res_nxt   = alu_res;
    if (flush) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE:
          if (accept) begin
            state_nxt = multi ? BUSY : DONE;
            ld_res    = !multi;
          end
        BUSY:
          if (cnt == '0) begin
            state_nxt = DONE;
            ld_res    = 1'b1;
            res_nxt   = it_res;
          end
        DONE:
          if (out_ready) begin
            if (accept) begin
              state_nxt = multi ? BUSY : DONE;
              ld_res    = !multi;
            end else begin
              state_nxt = IDLE;
            end
          end
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      result <= '0;
      req_q  <= '0;
      cnt    <= '0;
      hi     <= '0;
      lo     <= '0;
      mc     <= '0;
    end else begin
      if (ld_res) result <= res_nxt;
      if (accept) begin
        req_q <= '{op: op, a: operand1, b: operand2};
        hi    <= '0;
        lo    <= ma;
        mc    <= mb;
        cnt   <= CW'(XLEN-1);
      end else if (state == BUSY && !flush) begin
        hi <= hi_nxt;
        lo <= lo_nxt;
        if (cnt != '0) cnt <= cnt - 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_iter_alu.sv
// Directed self-checking bench for iter_alu with hand-computed expectations.
module tb_iter_alu;
  logic        clk, rst, in_valid, in_ready, out_valid, out_ready, flush;
  logic [4:0]  op;
  logic [31:0] operand1, operand2, result;
  int checks = 0;
  int errors = 0;

  iter_alu #(.XLEN(32)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .op(op),
    .operand1(operand1), .operand2(operand2), .out_valid(out_valid),
    .out_ready(out_ready), .result(result), .flush(flush)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Issue one request with out_ready high and check latency and result.
  task automatic run(input string tag, input logic [4:0] o, input logic [31:0] a,
                     input logic [31:0] b, input logic [31:0] exp, input int lat_exp);
    int lat;
    chk({tag, "_rdy"}, {31'b0, in_ready}, 32'd1);
    op = o; operand1 = a; operand2 = b; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    if (lat_exp > 1) chk({tag, "_busy_rdy"}, {31'b0, in_ready}, 32'd0);
    lat = 1;
    while (!out_valid && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    chk({tag, "_lat"}, 32'(lat), 32'(lat_exp));
    chk(tag, result, exp);
  endtask

  task automatic watch_quiet(input string tag, input int cycles);
    int seen;
    seen = 0;
    repeat (cycles) begin
      @(posedge clk); #1;
      if (out_valid) seen++;
    end
    chk(tag, 32'(seen), 32'd0);
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; flush = 1'b0;
    op = '0; operand1 = '0; operand2 = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ov", {31'b0, out_valid}, 32'd0);
    chk("rst_res", result, 32'd0);
    chk("rst_rdy", {31'b0, in_ready}, 32'd1);
    rst = 1'b0;

    run("add",    5'd0,  32'd5,        32'd7,        32'h0000000C, 1);
    chk("add_rdy_after", {31'b0, in_ready}, 32'd1);
    run("sub",    5'd1,  32'd5,        32'd7,        32'hFFFFFFFE, 1);
    run("xor",    5'd2,  32'hFF00FF00, 32'h0FF00FF0, 32'hF0F0F0F0, 1);
    run("or",     5'd3,  32'hFF000000, 32'h000000FF, 32'hFF0000FF, 1);
    run("and",    5'd4,  32'hFF00FF00, 32'h0FF00FF0, 32'h0F000F00, 1);
    run("sll",    5'd5,  32'h00000001, 32'h00000021, 32'h00000002, 1);
    run("srl",    5'd6,  32'h80000000, 32'h00000004, 32'h08000000, 1);
    run("sra",    5'd7,  32'h80000000, 32'h00000024, 32'hF8000000, 1);
    run("slt",    5'd8,  32'hFFFFFFFF, 32'd1,        32'd1,        1);
    run("sltu",   5'd9,  32'hFFFFFFFF, 32'd1,        32'd0,        1);
    run("pass2",  5'd10, 32'h12345678, 32'hCAFEBABE, 32'hCAFEBABE, 1);
    run("clr",    5'd11, 32'h0000F0F0, 32'h0000FFFF, 32'h00000F0F, 1);
    run("pass1",  5'd12, 32'h12345678, 32'hCAFEBABE, 32'h12345678, 1);
    run("op13",   5'd13, 32'h12345678, 32'hCAFEBABE, 32'd0,        1);
    run("op31",   5'd31, 32'h12345678, 32'hCAFEBABE, 32'd0,        1);

    run("mul",    5'd16, 32'hFFFFFFFD, 32'd7,        32'hFFFFFFEB, 33);
    run("mulh",   5'd17, 32'hFFFFFFFD, 32'd7,        32'hFFFFFFFF, 33);
    run("mulhu",  5'd19, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 33);
    run("mulhsu", 5'd18, 32'hFFFFFFFF, 32'd2,        32'hFFFFFFFF, 33);
    run("mul2",   5'd16, 32'd12345,    32'd1000,     32'h00BC5EA8, 33);

    run("div0",   5'd20, 32'd100,      32'd0,        32'hFFFFFFFF, 33);
    run("rem0",   5'd22, 32'd100,      32'd0,        32'd100,      33);
    run("divu0",  5'd21, 32'd100,      32'd0,        32'hFFFFFFFF, 33);
    run("remu0",  5'd23, 32'd100,      32'd0,        32'd100,      33);
    run("divovf", 5'd20, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 33);
    run("removf", 5'd22, 32'h80000000, 32'hFFFFFFFF, 32'd0,        33);
    run("rem_n7", 5'd22, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 33);
    run("div_n7", 5'd20, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 33);
    run("divu",   5'd21, 32'd100,      32'd7,        32'd14,       33);
    run("remu",   5'd23, 32'd100,      32'd7,        32'd2,        33);
    run("div_7n", 5'd20, 32'd7,        32'hFFFFFFFE, 32'hFFFFFFFD, 33);
    run("rem_7n", 5'd22, 32'd7,        32'hFFFFFFFE, 32'd1,        33);

    // Backpressure, then a back-to-back accept out of DONE.
    @(posedge clk); #1;
    out_ready = 1'b0;
    op = 5'd0; operand1 = 32'd1; operand2 = 32'd2; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("bp_ov", {31'b0, out_valid}, 32'd1);
    repeat (5) begin
      @(posedge clk); #1;
      chk("bp_hold_ov", {31'b0, out_valid}, 32'd1);
      chk("bp_hold_res", result, 32'd3);
      chk("bp_hold_rdy", {31'b0, in_ready}, 32'd0);
    end
    out_ready = 1'b1;
    op = 5'd0; operand1 = 32'd10; operand2 = 32'd20; in_valid = 1'b1;
    #1;
    chk("b2b_rdy", {31'b0, in_ready}, 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("b2b_ov", {31'b0, out_valid}, 32'd1);
    chk("b2b_res", result, 32'd30);

    // Flush at BUSY cycle 10.
    @(posedge clk); #1;
    op = 5'd16; operand1 = 32'd3; operand2 = 32'd4; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    chk("flush_idle_rdy", {31'b0, in_ready}, 32'd1);
    chk("flush_ov", {31'b0, out_valid}, 32'd0);
    watch_quiet("flush_no_ov", 40);
    chk("flush_res_kept", result, 32'd30);

    // Flush beats a simultaneous request.
    op = 5'd0; operand1 = 32'd1; operand2 = 32'd1; in_valid = 1'b1; flush = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; flush = 1'b0;
    chk("flush_vs_valid_ov", {31'b0, out_valid}, 32'd0);
    chk("flush_vs_valid_res", result, 32'd30);

    // Reset mid-BUSY.
    op = 5'd21; operand1 = 32'd100; operand2 = 32'd7; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    chk("rstbusy_ov", {31'b0, out_valid}, 32'd0);
    chk("rstbusy_res", result, 32'd0);
    chk("rstbusy_rdy", {31'b0, in_ready}, 32'd1);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("rstbusy_rdy_after", {31'b0, in_ready}, 32'd1);
    watch_quiet("rstbusy_no_ov", 40);

    // Reset while holding a result in DONE.
    out_ready = 1'b0;
    op = 5'd0; operand1 = 32'd4; operand2 = 32'd4; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("rstdone_pre_res", result, 32'd8);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("rstdone_ov", {31'b0, out_valid}, 32'd0);
    chk("rstdone_res", result, 32'd0);
    chk("rstdone_rdy", {31'b0, in_ready}, 32'd1);
    out_ready = 1'b1;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/iter_alu.md
ITER_ALU -- requirements
Module: iter_alu

Interface
REQ-001 SHALL have parameter XLEN, default 32, operand/result width; power of 2, >= 8.
REQ-002 SHALL have parameter SHW, default $clog2(XLEN), shift-amount width.
REQ-003 SHALL have port clk  input  1  sole clock, all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port in_valid  input  1  request present.
REQ-006 SHALL have port in_ready  output  1  block accepts request this cycle.
REQ-007 SHALL have port op  input  5  operation code (REQ-011).
REQ-008 SHALL have ports operand1, operand2  input  XLEN  source operands.
REQ-009 SHALL have ports out_valid  output  1, out_ready  input  1, result  output  XLEN  result handshake.
REQ-010 SHALL have port flush  input  1  discard in-flight request.

Function
REQ-011 Op codes SHALL be: 0 ADD, 1 SUB, 2 XOR, 3 OR, 4 AND, 5 SLL, 6 SRL, 7 SRA, 8 SLT, 9 SLTU, 10 PASS2 (operand2), 11 CLR (~operand1 & operand2), 12 PASS1 (operand1), 16 MUL, 17 MULH, 18 MULHSU, 19 MULHU, 20 DIV, 21 DIVU, 22 REM, 23 REMU; any other code yields result 0 with single-step latency.
REQ-012 Request accepted on any edge where in_valid && in_ready && !flush; operands and op captured then.
REQ-013 FSM states IDLE, BUSY, DONE; IDLE->DONE on accepted codes 0-15/other; IDLE->BUSY on accepted codes 16-23.
REQ-014 BUSY SHALL run exactly XLEN iteration cycles (down-counter loaded with XLEN-1), then ->DONE.
REQ-015 Latency: accept at edge N -> out_valid high after edge N+1 (single-step) or N+XLEN+1 (mul/div), fixed regardless of operand values.
REQ-016 out_valid high iff state DONE; result held stable while out_valid && !out_ready.
REQ-017 DONE->IDLE on out_ready with no new accept; DONE->DONE/BUSY when out_ready and a new request accepted same edge (back-to-back).
REQ-018 in_ready = (state==IDLE) || (state==DONE && out_ready); in_ready low in BUSY.
REQ-019 Shifts use operand2[SHW-1:0]; SRA sign-fills; SLT signed, SLTU unsigned, result 1 or 0 zero-extended.
REQ-020 Arithmetic modulo 2^XLEN; MUL low XLEN bits; MULH/MULHSU/MULHU high XLEN bits of 2*XLEN product with s*s, s*u, u*u operand interpretation.
REQ-021 Division restoring/non-restoring on magnitudes, sign fixed after: quotient sign = sign1 xor sign2, remainder sign = dividend sign.
REQ-022 Divide by zero: quotient all-ones, remainder = operand1, both signed and unsigned.
REQ-023 Signed overflow (most-negative / -1): quotient = operand1, remainder 0.
REQ-024 REQ-022/023 cases SHALL still take XLEN+1 cycles.
REQ-025 flush high at an edge: state->IDLE, out_valid 0 next cycle, pending result lost; flush beats simultaneous in_valid (no accept).
REQ-026 result SHALL not change except on DONE entry or reset.

Reset
REQ-027 rst high at an edge: state IDLE, out_valid 0, result 0, counter 0, captured operands 0; rst dominates flush and in_valid.
REQ-028 Reset mid-BUSY or in DONE SHALL discard operation; in_ready high first cycle after rst deasserts.

Verification
REQ-029 ADD 5,7 accepted edge N, out_ready 1 -> out_valid after N+1, result 0x0000000C, in_ready back high.
REQ-030 SRA 0x80000000 by 0x24 (shift 4) -> 0xF8000000; SLT 0xFFFFFFFF,1 -> 1; SLTU same -> 0.
REQ-031 MUL -3,7 -> 0xFFFFFFEB, MULH -> 0xFFFFFFFF, MULHU 0xFFFFFFFF,0xFFFFFFFF -> 0xFFFFFFFE, each out_valid exactly 33 cycles after accept.
REQ-032 DIV 100,0 -> 0xFFFFFFFF; REM 100,0 -> 100; DIV 0x80000000,-1 -> 0x80000000; REM -7,2 -> 0xFFFFFFFF; DIV -7,2 -> 0xFFFFFFFD.
REQ-033 out_ready low 5 cycles after DONE -> out_valid and result stable, in_ready 0; then out_ready with new ADD valid -> back-to-back accept.
REQ-034 flush at BUSY cycle 10 -> IDLE next cycle, no out_valid ever for that op; rst in BUSY -> all outputs reset values next cycle.
